// File: rtl/fpu_dispatch.sv
// rtl/fpu_dispatch.sv - in-order issue/complete controller between the FP execute stage and per-operation FPU units
//
// Accepts one FP op per cycle, steers its operands to the unit chosen by the op
// code, and returns results to the core strictly in issue order with their
// destination tag. An order FIFO records every accepted op. Only the unit named
// by the FIFO head may hand back a result, so units that finish early are
// back-pressured until their turn comes.
//
// Optional feature macro: FPU_DISPATCH_STATS_EN. When it is defined, two 32-bit
// saturating counters are added: stat_issue_stall and stat_result_wait.
//
// Ports:
//   CLK, RESET                clock, asynchronous active-low reset
//   in_valid/in_ready         op offer from the core and acceptance
//   in_op, in_a, in_b, in_tag op code (unit select), operands, destination tag
//   u_valid/u_ready           one-hot operand valid and per-unit operand ready
//   u_a, u_b                  operands, shared by all units
//   u_res_valid/u_res_ready   per-unit result valid and ready (at most one ready high)
//   u_res_data                unit k result at bits [32k+31:32k]
//   out_valid/out_ready       in-order result stream to the core
//   out_data, out_tag         result value and its tag
//   out_illegal               result is the canonical NaN produced for an illegal op code
//   busy                      an op is in flight or held in a register
//   stat_issue_stall          cycles with in_valid && !in_ready (stats build only)
//   stat_result_wait          cycles the head waits on its unit's result (stats build only)

module fpu_dispatch #(
    parameter int NUM_UNITS = 5,
    parameter int OP_W      = 3,
    parameter int TAG_W     = 6,
    parameter int DEPTH     = 8
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           in_op,
    input  logic [31:0]               in_a,
    input  logic [31:0]               in_b,
    input  logic [TAG_W-1:0]          in_tag,
    output logic [NUM_UNITS-1:0]      u_valid,
    input  logic [NUM_UNITS-1:0]      u_ready,
    output logic [31:0]               u_a,
    output logic [31:0]               u_b,
    input  logic [NUM_UNITS-1:0]      u_res_valid,
    output logic [NUM_UNITS-1:0]      u_res_ready,
    input  logic [32*NUM_UNITS-1:0]   u_res_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic [TAG_W-1:0]          out_tag,
    output logic                      out_illegal,
    output logic                      busy
`ifdef FPU_DISPATCH_STATS_EN
    ,
    output logic [31:0]               stat_issue_stall,
    output logic [31:0]               stat_result_wait
`endif
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;

    // Issue register
    logic             iss_valid;
    logic [OP_W-1:0]  iss_op;
    logic [31:0]      iss_a;
    logic [31:0]      iss_b;

    // Order FIFO
    logic [OP_W-1:0]  fifo_op  [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic             fifo_ill [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;

    logic             fifo_full;
    logic             head_valid;
    logic             head_ill;
    logic [OP_W-1:0]  head_op;
    logic [TAG_W-1:0] head_tag;

    logic             in_legal;
    logic             accept;
    logic             iss_fire;
    logic             out_free;
    logic             res_fire;
    logic             ill_pop;
    logic             pop;
    logic [31:0]      res_data;
`ifdef FPU_DISPATCH_STATS_EN
    logic             res_wait;
`endif

    assign in_legal   = int'(in_op) < NUM_UNITS;
    assign fifo_full  = fifo_count == CNT_W'(DEPTH);
    // Full is taken from the registered count only, so a pop in the same
    // cycle does not open a slot until the next cycle.
    assign in_ready   = RESET && !fifo_full && (!iss_valid || iss_fire);
    assign accept     = in_valid && in_ready;

    assign head_valid = fifo_count != '0;
    assign head_op    = fifo_op[rd_ptr];
    assign head_tag   = fifo_tag[rd_ptr];
    assign head_ill   = fifo_ill[rd_ptr];

    assign out_free   = !out_valid || out_ready;
    assign ill_pop    = head_valid && head_ill && out_free;
    assign pop        = res_fire || ill_pop;

    assign u_a        = iss_a;
    assign u_b        = iss_b;
    assign busy       = iss_valid || head_valid || out_valid;

    // Operand steering and result selection. Only the head's unit is ever
    // offered u_res_ready; the others are held off until they reach the head.
    always_comb begin
        u_valid     = '0;
        u_res_ready = '0;
        res_data    = '0;
`ifdef FPU_DISPATCH_STATS_EN
        res_wait    = 1'b0;
`endif
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (iss_valid && iss_op == OP_W'(k)) begin
                u_valid[k] = 1'b1;
            end
            if (head_valid && !head_ill && head_op == OP_W'(k)) begin
                u_res_ready[k] = out_free;
                res_data       = u_res_data[32*k +: 32];
`ifdef FPU_DISPATCH_STATS_EN
                res_wait       = !u_res_valid[k];
`endif
            end
        end
    end

    assign iss_fire = |(u_valid & u_ready);
    assign res_fire = |(u_res_valid & u_res_ready);

    // Illegal ops get an order slot but never occupy the issue register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            iss_valid <= 1'b0;
            iss_op    <= '0;
            iss_a     <= '0;
            iss_b     <= '0;
        end else if (accept && in_legal) begin
            iss_valid <= 1'b1;
            iss_op    <= in_op;
            iss_a     <= in_a;
            iss_b     <= in_b;
        end else if (iss_fire) begin
            iss_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            fifo_op[wr_ptr]  <= in_op;
            fifo_tag[wr_ptr] <= in_tag;
            fifo_ill[wr_ptr] <= !in_legal;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (pop) begin
            out_valid   <= 1'b1;
            out_tag     <= head_tag;
            out_data    <= ill_pop ? QNAN : res_data;
            out_illegal <= ill_pop;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef FPU_DISPATCH_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_issue_stall <= '0;
            stat_result_wait <= '0;
        end else begin
            if (in_valid && !in_ready && stat_issue_stall != '1) begin
                stat_issue_stall <= stat_issue_stall + 1'b1;
            end
            if (res_wait && stat_result_wait != '1) begin
                stat_result_wait <= stat_result_wait + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fpu_dispatch.sv
// tb/tb_fpu_dispatch.sv - self-checking bench for fpu_dispatch with behavioural FPU unit models
module tb_fpu_dispatch;
    localparam int NU    = 5;
    localparam int OP_W  = 3;
    localparam int TAG_W = 6;
    localparam int DEPTH = 8;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [OP_W-1:0]   in_op = '0;
    logic [31:0]       in_a = '0;
    logic [31:0]       in_b = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [NU-1:0]     u_valid;
    logic [NU-1:0]     u_ready = '1;
    logic [31:0]       u_a;
    logic [31:0]       u_b;
    logic [NU-1:0]     u_res_valid = '0;
    logic [NU-1:0]     u_res_ready;
    logic [32*NU-1:0]  u_res_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_illegal;
    logic              busy;
`ifdef FPU_DISPATCH_STATS_EN
    logic [31:0]       stat_issue_stall;
    logic [31:0]       stat_result_wait;
`endif

    fpu_dispatch #(.NUM_UNITS(NU), .OP_W(OP_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .u_valid(u_valid), .u_ready(u_ready), .u_a(u_a), .u_b(u_b),
        .u_res_valid(u_res_valid), .u_res_ready(u_res_ready), .u_res_data(u_res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_illegal(out_illegal), .busy(busy)
`ifdef FPU_DISPATCH_STATS_EN
        , .stat_issue_stall(stat_issue_stall), .stat_result_wait(stat_result_wait)
`endif
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int stim_timeouts = 0;
    int proto_err = 0;
    int total_opnd = 0;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               cyc;
    } res_t;
    typedef struct {
        int unit;
        bit ill;
    } pend_t;

    res_t  expq[$];
    res_t  obsq[$];
    pend_t pendq[$];

    // Unit models: pipelined, fixed latency, results queue until consumed.
    int          lat [NU];
    bit          hold [NU];
    logic [31:0] rb_data [NU][32];
    int          rb_due [NU][32];
    int          rb_wp [NU];
    int          rb_rp [NU];
    int          cyc = 0;
    int          rdy_pct = 100;
    int          out_pct = 100;

    // Sampled (negedge) view of the last cycle
    bit            s_acc;
    bit            s_out_valid;
    logic [31:0]   s_out_data;
    logic [TAG_W-1:0] s_out_tag;
    logic [NU-1:0] s_u_valid, s_u_res_valid, s_u_res_ready, s_resh;
    int            s_cyc;

    function automatic real f2d(input logic [31:0] x);
        logic [10:0] e;
        e = 11'(x[30:23]) + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] d2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] unit_fn(input int k, input logic [31:0] a, input logic [31:0] b);
        real x, y, r;
        x = f2d(a);
        y = f2d(b);
        case (k)
            0:       r = x + y;
            1:       r = x - y;
            2:       r = x * y;
            3:       r = x / y;
            default: r = $sqrt(x);
        endcase
        return d2f(r);
    endfunction

    function automatic logic [31:0] rand_operand();
        return {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    task automatic refresh_units();
        for (int k = 0; k < NU; k++) begin
            int idx;
            idx = rb_rp[k] & 31;
            u_res_valid[k] = (rb_wp[k] != rb_rp[k]) && !hold[k] && (rb_due[k][idx] <= cyc);
            u_res_data[32*k +: 32] = rb_data[k][idx];
        end
    endtask

    task automatic reset_units();
        for (int k = 0; k < NU; k++) begin
            rb_wp[k] = 0;
            rb_rp[k] = 0;
            hold[k]  = 1'b0;
        end
        refresh_units();
    endtask

    task automatic set_lat(input int l);
        for (int k = 0; k < NU; k++) lat[k] = l;
    endtask

    // One clock: observe at negedge, advance unit models just after posedge.
    task automatic cycle();
        logic [31:0]   ua, ub;
        logic [NU-1:0] opnd;
        int            c;
        @(negedge CLK);
        c             = cyc;
        s_cyc         = cyc;
        s_acc         = in_valid && in_ready;
        s_out_valid   = out_valid;
        s_out_data    = out_data;
        s_out_tag     = out_tag;
        s_u_valid     = u_valid;
        s_u_res_valid = u_res_valid;
        s_u_res_ready = u_res_ready;
        s_resh        = u_res_valid & u_res_ready;
        opnd          = u_valid & u_ready;
        ua            = u_a;
        ub            = u_b;
        if ($countones(u_valid) > 1 || $countones(u_res_ready) > 1) proto_err++;
        for (int k = 0; k < NU; k++) begin
            if (u_res_ready[k] && (pendq.size() == 0 || pendq[0].ill || pendq[0].unit != k)) proto_err++;
        end
        if (|s_resh) begin
            if (pendq.size() != 0) void'(pendq.pop_front());
        end else if (pendq.size() != 0 && pendq[0].ill && (!out_valid || out_ready)) begin
            void'(pendq.pop_front());
        end
        if (s_acc) begin
            pend_t p;
            res_t  e;
            p.unit = int'(in_op);
            p.ill  = int'(in_op) >= NU;
            e.data = p.ill ? 32'h7FC0_0000 : unit_fn(p.unit, in_a, in_b);
            e.tag  = in_tag;
            e.ill  = p.ill;
            e.cyc  = c;
            pendq.push_back(p);
            expq.push_back(e);
        end
        if (out_valid && out_ready) begin
            res_t o;
            o.data = out_data;
            o.tag  = out_tag;
            o.ill  = out_illegal;
            o.cyc  = c;
            obsq.push_back(o);
        end
        @(posedge CLK);
        #1;
        cyc++;
        for (int k = 0; k < NU; k++) begin
            if (opnd[k]) begin
                rb_data[k][rb_wp[k] & 31] = unit_fn(k, ua, ub);
                rb_due[k][rb_wp[k] & 31]  = c + lat[k];
                rb_wp[k]++;
                total_opnd++;
            end
            if (s_resh[k]) rb_rp[k]++;
            u_ready[k] = ($urandom_range(1, 100) <= rdy_pct);
        end
        out_ready = ($urandom_range(1, 100) <= out_pct);
        refresh_units();
    endtask

    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input int tag);
        in_valid = 1'b1;
        in_op    = OP_W'(op);
        in_a     = a;
        in_b     = b;
        in_tag   = TAG_W'(tag);
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (s_acc) break;
        end
        if (!s_acc) stim_timeouts++;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max);
        for (int i = 0; i < max; i++) begin
            if (obsq.size() == expq.size() && pendq.size() == 0 && !out_valid) break;
            cycle();
        end
        if (obsq.size() != expq.size()) stim_timeouts++;
    endtask

    task automatic clear_sb();
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_reset();
        #1 RESET = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        vectors++; if (in_ready !== 1'b0)     begin miscompares++; $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
        vectors++; if (u_valid !== '0)        begin miscompares++; $display("FAIL reset_u_valid got=%0h want=0", u_valid); end
        vectors++; if (u_res_ready !== '0)    begin miscompares++; $display("FAIL reset_u_res_ready got=%0h want=0", u_res_ready); end
        vectors++; if (out_valid !== 1'b0)    begin miscompares++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        vectors++; if (out_data !== 32'h0)    begin miscompares++; $display("FAIL reset_out_data got=%0h want=0", out_data); end
        vectors++; if (out_tag !== '0)        begin miscompares++; $display("FAIL reset_out_tag got=%0h want=0", out_tag); end
        vectors++; if (out_illegal !== 1'b0)  begin miscompares++; $display("FAIL reset_out_illegal got=%0b want=0", out_illegal); end
        vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL reset_busy got=%0b want=0", busy); end
`ifdef FPU_DISPATCH_STATS_EN
        vectors++; if (stat_issue_stall !== 32'h0 || stat_result_wait !== 32'h0) begin
            miscompares++; $display("FAIL reset_stats got=%0h/%0h want=0/0", stat_issue_stall, stat_result_wait); end
`endif
        RESET = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b1)     begin miscompares++; $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
    endtask

    task automatic test_single_add();
        logic [NU-1:0] uv;
        int first;
        set_lat(3);
        rdy_pct = 100; out_pct = 100; u_ready = '1; out_ready = 1'b1;
        clear_sb();
        issue(0, 32'h3F80_0000, 32'h4000_0000, 5);
        first = 0;
        uv = '0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (k == 1) uv = s_u_valid;
            if (s_out_valid && first == 0) first = k;
        end
        vectors++; if (uv !== 5'b00001) begin miscompares++; $display("FAIL add_u_valid got=%b want=00001", uv); end
        vectors++; if (first != 5)      begin miscompares++; $display("FAIL add_latency got=%0d want=5", first); end
        vectors++; if (obsq.size() != 1) begin miscompares++; $display("FAIL add_count got=%0d want=1", obsq.size()); end
        if (obsq.size() >= 1) begin
            vectors++; if (obsq[0].data !== 32'h4040_0000) begin miscompares++; $display("FAIL add_data got=%h want=40400000", obsq[0].data); end
            vectors++; if (obsq[0].tag !== 6'd5 || obsq[0].ill !== 1'b0) begin
                miscompares++; $display("FAIL add_tag got=%0d/%0b want=5/0", obsq[0].tag, obsq[0].ill); end
        end
    endtask

    task automatic test_reorder();
        int  wait_cnt;
        bit  early;
        set_lat(3);
        lat[3] = 20;
        clear_sb();
        issue(3, rand_operand(), rand_operand(), 1);
        issue(0, rand_operand(), rand_operand(), 2);
        wait_cnt = 0;
        early = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (s_u_res_valid[0] && !s_u_res_ready[0]) wait_cnt++;
            if (s_resh[0] && obsq.size() == 0) early = 1;
            if (obsq.size() == 2) break;
        end
        vectors++; if (obsq.size() != 2) begin miscompares++; $display("FAIL reorder_count got=%0d want=2", obsq.size()); end
        vectors++; if (early)            begin miscompares++; $display("FAIL reorder_early_pop got=1 want=0"); end
        vectors++; if (wait_cnt != 17)   begin miscompares++; $display("FAIL reorder_add_wait got=%0d want=17", wait_cnt); end
        if (obsq.size() == 2) begin
            vectors++; if (obsq[0].tag !== 6'd1 || obsq[1].tag !== 6'd2) begin
                miscompares++; $display("FAIL reorder_tags got=%0d,%0d want=1,2", obsq[0].tag, obsq[1].tag); end
            vectors++; if (obsq[0].data !== expq[0].data || obsq[1].data !== expq[1].data) begin
                miscompares++; $display("FAIL reorder_data got=%h,%h want=%h,%h", obsq[0].data, obsq[1].data, expq[0].data, expq[1].data); end
            vectors++; if (obsq[1].cyc - obsq[0].cyc != 1) begin
                miscompares++; $display("FAIL reorder_gap got=%0d want=1", obsq[1].cyc - obsq[0].cyc); end
        end
    endtask

    task automatic test_full();
        int ops [9];
        logic [31:0] as [9], bs [9];
        int idx, pop_c, acc_c;
        set_lat(2);
        clear_sb();
        for (int k = 0; k < NU; k++) hold[k] = 1'b1;
        refresh_units();
        for (int i = 0; i < 9; i++) begin
            ops[i] = $urandom_range(0, NU - 1);
            as[i]  = rand_operand();
            bs[i]  = rand_operand();
        end
        idx = 0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_op = OP_W'(ops[idx]); in_a = as[idx]; in_b = bs[idx]; in_tag = TAG_W'(idx + 50);
            cycle();
            if (s_acc) idx++;
        end
        vectors++; if (idx != 8)         begin miscompares++; $display("FAIL full_accepted got=%0d want=8", idx); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got=%0b want=0", in_ready); end
        for (int k = 0; k < NU; k++) hold[k] = 1'b0;
        refresh_units();
        pop_c = -1;
        acc_c = -1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (|s_resh && pop_c < 0) pop_c = s_cyc;
            if (s_acc) begin acc_c = s_cyc; break; end
        end
        in_valid = 1'b0;
        vectors++; if (pop_c < 0 || acc_c != pop_c + 1) begin
            miscompares++; $display("FAIL full_release got=accept@%0d want=pop@%0d+1", acc_c, pop_c); end
        drain(200);
        vectors++; if (obsq.size() != 9) begin miscompares++; $display("FAIL full_drain got=%0d want=9", obsq.size()); end
        for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
            vectors++; if (obsq[i].data !== expq[i].data || obsq[i].tag !== expq[i].tag) begin
                miscompares++; $display("FAIL full_result[%0d] got=%h/%0d want=%h/%0d", i, obsq[i].data, obsq[i].tag, expq[i].data, expq[i].tag); end
        end
    endtask

    task automatic test_illegal();
        int opnd0;
        for (int k = 0; k < NU; k++) lat[k] = $urandom_range(1, 5);
        clear_sb();
        opnd0 = total_opnd;
        issue(1, rand_operand(), rand_operand(), 3);
        issue(7, rand_operand(), rand_operand(), 9);
        issue(2, rand_operand(), rand_operand(), 4);
        issue(5, rand_operand(), rand_operand(), 11);
        drain(100);
        vectors++; if (total_opnd - opnd0 != 2) begin
            miscompares++; $display("FAIL illegal_unit_handshakes got=%0d want=2", total_opnd - opnd0); end
        vectors++; if (obsq.size() != 4) begin miscompares++; $display("FAIL illegal_count got=%0d want=4", obsq.size()); end
        if (obsq.size() == 4) begin
            vectors++; if (obsq[0].tag !== 6'd3 || obsq[1].tag !== 6'd9 || obsq[2].tag !== 6'd4 || obsq[3].tag !== 6'd11) begin
                miscompares++; $display("FAIL illegal_tags got=%0d,%0d,%0d,%0d want=3,9,4,11", obsq[0].tag, obsq[1].tag, obsq[2].tag, obsq[3].tag); end
            vectors++; if (obsq[1].data !== 32'h7FC0_0000 || obsq[1].ill !== 1'b1) begin
                miscompares++; $display("FAIL illegal_op7 got=%h/%0b want=7fc00000/1", obsq[1].data, obsq[1].ill); end
            vectors++; if (obsq[3].data !== 32'h7FC0_0000 || obsq[3].ill !== 1'b1) begin
                miscompares++; $display("FAIL illegal_op5 got=%h/%0b want=7fc00000/1", obsq[3].data, obsq[3].ill); end
            vectors++; if (obsq[0].data !== expq[0].data || obsq[0].ill !== 1'b0 || obsq[2].data !== expq[2].data) begin
                miscompares++; $display("FAIL illegal_legal_data got=%h,%h want=%h,%h", obsq[0].data, obsq[2].data, expq[0].data, expq[2].data); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]      d;
        logic [TAG_W-1:0] t;
        bit               seen;
        set_lat(3);
        clear_sb();
        out_pct = 0;
        out_ready = 1'b0;
        issue(0, rand_operand(), rand_operand(), 20);
        issue(1, rand_operand(), rand_operand(), 21);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (s_out_valid) begin seen = 1; break; end
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL bp_out_valid got=0 want=1"); end
        d = out_data;
        t = out_tag;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vectors++; if (s_out_valid !== 1'b1 || s_out_data !== d || s_out_tag !== t) begin
                miscompares++; $display("FAIL bp_stable[%0d] got=%0b/%h/%0d want=1/%h/%0d", i, s_out_valid, s_out_data, s_out_tag, d, t); end
            vectors++; if (s_u_res_ready !== '0) begin
                miscompares++; $display("FAIL bp_res_ready[%0d] got=%b want=0", i, s_u_res_ready); end
        end
        vectors++; if (obsq.size() != 0) begin miscompares++; $display("FAIL bp_no_pop got=%0d want=0", obsq.size()); end
        out_pct = 100;
        out_ready = 1'b1;
        drain(30);
        vectors++; if (obsq.size() != 2) begin miscompares++; $display("FAIL bp_drain got=%0d want=2", obsq.size()); end
        if (obsq.size() == 2) begin
            vectors++; if (obsq[1].cyc - obsq[0].cyc != 1) begin
                miscompares++; $display("FAIL bp_gap got=%0d want=1", obsq[1].cyc - obsq[0].cyc); end
            vectors++; if (obsq[0].tag !== 6'd20 || obsq[1].tag !== 6'd21 || obsq[0].data !== expq[0].data || obsq[1].data !== expq[1].data) begin
                miscompares++; $display("FAIL bp_results got=%0d:%h,%0d:%h want=20:%h,21:%h", obsq[0].tag, obsq[0].data, obsq[1].tag, obsq[1].data, expq[0].data, expq[1].data); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b;
        set_lat(20);
        clear_sb();
        for (int i = 0; i < 3; i++) issue($urandom_range(0, NU - 1), rand_operand(), rand_operand(), 40 + i);
        RESET = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL rstmid_busy got=%0b/%0b want=0/0", busy, out_valid); end
        vectors++; if (in_ready !== 1'b0 || u_valid !== '0 || u_res_ready !== '0) begin
            miscompares++; $display("FAIL rstmid_handshakes got=%0b/%b/%b want=0/0/0", in_ready, u_valid, u_res_ready); end
        reset_units();
        pendq.delete();
        clear_sb();
        cycle();
        RESET = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++; $display("FAIL rstmid_release got=%0b/%0b want=0/1", busy, in_ready); end
        set_lat(2);
        a = rand_operand();
        b = rand_operand();
        issue(4, a, b, 33);
        drain(40);
        vectors++; if (obsq.size() != 1) begin miscompares++; $display("FAIL rstmid_count got=%0d want=1", obsq.size()); end
        if (obsq.size() == 1) begin
            vectors++; if (obsq[0].tag !== 6'd33 || obsq[0].data !== unit_fn(4, a, b)) begin
                miscompares++; $display("FAIL rstmid_result got=%0d/%h want=33/%h", obsq[0].tag, obsq[0].data, unit_fn(4, a, b)); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < NU; k++) lat[k] = $urandom_range(1, 8);
        rdy_pct = 70;
        out_pct = 70;
        clear_sb();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) cycle();
            issue($urandom_range(0, 7), rand_operand(), rand_operand(), $urandom_range(0, 63));
        end
        drain(3000);
        rdy_pct = 100;
        out_pct = 100;
        vectors++; if (obsq.size() != 300) begin miscompares++; $display("FAIL rand_count got=%0d want=300", obsq.size()); end
        for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
            vectors++; if (obsq[i].data !== expq[i].data || obsq[i].tag !== expq[i].tag || obsq[i].ill !== expq[i].ill) begin
                miscompares++; $display("FAIL rand_result[%0d] got=%h/%0d/%0b want=%h/%0d/%0b", i, obsq[i].data, obsq[i].tag, obsq[i].ill, expq[i].data, expq[i].tag, expq[i].ill); end
        end
    endtask

    initial begin
        set_lat(3);
        reset_units();
        test_reset();
        test_single_add();
        test_reorder();
        test_full();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_random();
        vectors++; if (proto_err != 0) begin miscompares++; $display("FAIL protocol got=%0d violations want=0", proto_err); end
        vectors++; if (stim_timeouts != 0) begin miscompares++; $display("FAIL timeouts got=%0d want=0", stim_timeouts); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
